// File: rtl/rs232_ctrl_monitor_if.sv
// rtl/rs232_ctrl_monitor_if.sv - signal bundle for the RS232 control-line monitor
//
// Purpose: groups the control-line inputs, mode/clear controls and the
// per-channel level/edge/LED outputs of rs232_ctrl_monitor.
// Ports (signals):
//   ctrl_in [N_CH] raw asynchronous control lines (bit 0 = DTR, bit 1 = RTS)
//   mode    [2]    LED mode: 00 level, 01 inverted level, 10 toggle, 11 stretch
//   clr     [1]    synchronous clear of toggle and stretch state
//   level   [N_CH] debounced line levels
//   rise    [N_CH] one-cycle pulse on an accepted 0->1 change
//   fall    [N_CH] one-cycle pulse on an accepted 1->0 change
//   led     [N_CH] LED drive
// Modports: master drives the inputs, slave is the monitor itself.
interface rs232_ctrl_monitor_if #(
  parameter int N_CH = 2
);
  logic [N_CH-1:0] ctrl_in;
  logic [1:0]      mode;
  logic            clr;
  logic [N_CH-1:0] level;
  logic [N_CH-1:0] rise;
  logic [N_CH-1:0] fall;
  logic [N_CH-1:0] led;

  modport master (
    output ctrl_in, mode, clr,
    input  level, rise, fall, led
  );

  modport slave (
    input  ctrl_in, mode, clr,
    output level, rise, fall, led
  );
endinterface

// File: rtl/rs232_ctrl_monitor.sv
// rtl/rs232_ctrl_monitor.sv - synchronise, debounce and edge-detect RS232 control lines
//
// Purpose: each channel of ctrl_in is passed through a SYNC_STAGES flop
// synchroniser, debounced (a new value must persist DEB_CYCLES cycles),
// edge-detected, and used to drive an LED in one of four display modes.
// Ports:
//   clk   system clock, the only clock in the block
//   rstn  asynchronous active-low reset
//   bus   rs232_ctrl_monitor_if.slave: ctrl_in, mode, clr in; level, rise,
//         fall, led out
module rs232_ctrl_monitor #(
  parameter int N_CH           = 2,
  parameter int SYNC_STAGES    = 2,
  parameter int DEB_CYCLES     = 1200,
  parameter int STRETCH_CYCLES = 1200000
) (
  input  logic                clk,
  input  logic                rstn,
  rs232_ctrl_monitor_if.slave bus
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int SW = $clog2(STRETCH_CYCLES + 1);

  logic [N_CH-1:0] sync_q [SYNC_STAGES];
  logic [N_CH-1:0] s;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= bus.ctrl_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic [DW-1:0] deb_cnt;
    logic [SW-1:0] str_cnt;
    logic          lvl;
    logic          rse;
    logic          fll;
    logic          tog;
    logic          accept;
    logic          stretch_on;

    // The DEB_CYCLES-th consecutive cycle of disagreement accepts the new value.
    assign accept     = (s[c] != lvl) && (deb_cnt == DW'(DEB_CYCLES - 1));
    assign stretch_on = (str_cnt != '0);

    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        deb_cnt <= '0;
        str_cnt <= '0;
        lvl     <= 1'b0;
        rse     <= 1'b0;
        fll     <= 1'b0;
        tog     <= 1'b0;
      end else begin
        rse <= accept & s[c];
        fll <= accept & ~s[c];

        // Agreement (or acceptance) restarts the count, so any bounce starts over.
        if ((s[c] == lvl) || accept) deb_cnt <= '0;
        else                         deb_cnt <= deb_cnt + DW'(1);

        if (accept) lvl <= s[c];

        // clr beats a coincident edge for toggle/stretch; level still updates above.
        if (bus.clr) begin
          tog     <= 1'b0;
          str_cnt <= '0;
        end else begin
          if (accept && s[c]) tog <= ~tog;
          if (accept)                str_cnt <= SW'(STRETCH_CYCLES);
          else if (str_cnt != '0)    str_cnt <= str_cnt - SW'(1);
        end
      end
    end

    assign bus.level[c] = lvl;
    assign bus.rise[c]  = rse;
    assign bus.fall[c]  = fll;
    assign bus.led[c]   = (bus.mode == 2'b00) ? lvl  :
                          (bus.mode == 2'b01) ? ~lvl :
                          (bus.mode == 2'b10) ? tog  : stretch_on;
  end

endmodule

// File: tb/tb_rs232_ctrl_monitor.sv
// tb/tb_rs232_ctrl_monitor.sv - self-checking bench for rs232_ctrl_monitor
module tb_rs232_ctrl_monitor;

  localparam int SYNC    = 2;
  localparam int DEB     = 4;
  localparam int STRETCH = 10;

  logic clk;
  logic rstn;
  int   total = 0;
  int   bad   = 0;

  rs232_ctrl_monitor_if #(.N_CH(2)) bus ();

  rs232_ctrl_monitor #(
    .N_CH(2), .SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .STRETCH_CYCLES(STRETCH)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: s is the input sampled SYNC edges ago; a channel flips
  // once s has disagreed with the level for DEB consecutive edges. Toggle is the
  // parity of rises since the last clear; stretch is "fewer than STRETCH edges
  // since the most recent accepted edge".
  int         cyc = 0;
  logic [1:0] hist[$];
  logic [1:0] m_level = '0;
  logic [1:0] m_rise  = '0;
  logic [1:0] m_fall  = '0;
  logic [1:0] m_par   = '0;
  logic [1:0] m_have  = '0;
  int         run[2]       = '{0, 0};
  int         last_edge[2] = '{0, 0};

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      hist.delete();
      m_level = '0; m_rise = '0; m_fall = '0; m_par = '0; m_have = '0;
      run = '{0, 0};
    end else begin
      logic [1:0] s_pre;
      s_pre = (hist.size() >= SYNC) ? hist[hist.size()-SYNC] : 2'b00;
      hist.push_back(bus.ctrl_in);
      if (hist.size() > SYNC) void'(hist.pop_front());
      cyc++;
      m_rise = '0;
      m_fall = '0;
      for (int c = 0; c < 2; c++) begin
        if (s_pre[c] != m_level[c]) begin
          run[c]++;
          if (run[c] == DEB) begin
            run[c] = 0;
            m_level[c] = s_pre[c];
            if (s_pre[c]) m_rise[c] = 1'b1;
            else          m_fall[c] = 1'b1;
          end
        end else begin
          run[c] = 0;
        end
        if (bus.clr) begin
          m_have[c] = 1'b0;
          m_par[c]  = 1'b0;
        end else if (m_rise[c] || m_fall[c]) begin
          m_have[c]    = 1'b1;
          last_edge[c] = cyc;
          if (m_rise[c]) m_par[c] = ~m_par[c];
        end
      end
    end
  end

  always @(posedge clk) begin
    logic [1:0] exp_led;
    #3;
    for (int c = 0; c < 2; c++) begin
      case (bus.mode)
        2'b00:   exp_led[c] = m_level[c];
        2'b01:   exp_led[c] = ~m_level[c];
        2'b10:   exp_led[c] = m_par[c];
        default: exp_led[c] = m_have[c] && ((cyc - last_edge[c]) < STRETCH);
      endcase
    end
    chk("model_level", bus.level, m_level);
    chk("model_rise",  bus.rise,  m_rise);
    chk("model_fall",  bus.fall,  m_fall);
    chk("model_led",   bus.led,   exp_led);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive von, switch to voff after 'width' edges, observe channel ch for n edges.
  task automatic watch(input logic [1:0] von, input logic [1:0] voff, input int width,
                       input int n, input int ch, output int r_at, output int f_at,
                       output int r_cnt, output int led_cnt);
    r_at = 0; f_at = 0; r_cnt = 0; led_cnt = 0;
    bus.ctrl_in = von;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #3;
      if (bus.rise[ch]) begin
        r_cnt++;
        if (r_at == 0) r_at = k;
      end
      if (bus.fall[ch] && f_at == 0) f_at = k;
      if (bus.led[ch]) led_cnt++;
      @(negedge clk);
      if (k == width) bus.ctrl_in = voff;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    int r_at, f_at, r_cnt, led_cnt, lat;
    rstn = 1'b0;
    bus.ctrl_in = 2'b11;
    bus.mode = 2'b00;
    bus.clr = 1'b0;
    idle(3);
    chk("rst_level", bus.level, 2'b00);
    chk("rst_rise",  bus.rise,  2'b00);
    chk("rst_fall",  bus.fall,  2'b00);
    chk("rst_led",   bus.led,   2'b00);

    // Release with lines held high: rise on both channels SYNC+DEB edges later.
    rstn = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #3;
      if (bus.rise == 2'b11) begin
        lat = k;
        break;
      end
    end
    @(negedge clk);
    chki("rst_latency", lat, 6);
    chk("rst_level_hi", bus.level, 2'b11);

    bus.ctrl_in = 2'b00;
    idle(12);

    // Glitch of 3 cycles is rejected; 4 cycles is accepted.
    watch(2'b01, 2'b00, 3, 12, 0, r_at, f_at, r_cnt, led_cnt);
    chki("glitch_rise_cnt", r_cnt, 0);
    chk("glitch_level", bus.level, 2'b00);
    watch(2'b01, 2'b00, 4, 14, 0, r_at, f_at, r_cnt, led_cnt);
    chki("pulse4_rise_at", r_at, 6);
    chki("pulse4_fall_at", f_at, 10);
    chki("pulse4_rise_cnt", r_cnt, 1);

    // Toggle mode on ch1.
    bus.mode = 2'b10;
    bus.clr = 1'b1;
    @(posedge clk); #3;
    chk("tog_clr_led", bus.led, 2'b00);
    @(negedge clk);
    bus.clr = 1'b0;
    watch(2'b10, 2'b00, 6, 12, 1, r_at, f_at, r_cnt, led_cnt);
    chk("tog_led_1", bus.led, 2'b10);
    watch(2'b10, 2'b00, 6, 12, 1, r_at, f_at, r_cnt, led_cnt);
    chk("tog_led_2", bus.led, 2'b00);
    watch(2'b10, 2'b10, 99, 8, 1, r_at, f_at, r_cnt, led_cnt);
    chk("tog_led_3", bus.led, 2'b10);
    bus.clr = 1'b1;
    @(posedge clk); #3;
    chk("tog_clr2_led", bus.led, 2'b00);
    chk("tog_clr2_level", bus.level, 2'b10);
    @(negedge clk);
    bus.clr = 1'b0;

    // Stretch mode on ch0: single edge, then a retrigger 6 cycles in.
    bus.ctrl_in = 2'b00;
    idle(20);
    bus.mode = 2'b11;
    watch(2'b01, 2'b00, 20, 24, 0, r_at, f_at, r_cnt, led_cnt);
    chki("str_rise_at", r_at, 6);
    chki("str_led_cycles", led_cnt, 10);
    idle(20);
    watch(2'b01, 2'b00, 6, 30, 0, r_at, f_at, r_cnt, led_cnt);
    chki("retrig_fall_at", f_at, 12);
    chki("retrig_led_cycles", led_cnt, 16);

    // Inverted level mode, then reset in the middle of a debounce.
    bus.ctrl_in = 2'b10;
    idle(14);
    bus.mode = 2'b01;
    @(posedge clk); #3;
    chk("inv_led", bus.led, 2'b01);
    chk("inv_level", bus.level, 2'b10);
    @(negedge clk);
    bus.ctrl_in = 2'b11;
    idle(4);
    rstn = 1'b0;
    bus.ctrl_in = 2'b00;
    @(posedge clk); #3;
    chk("midrst_led", bus.led, 2'b11);
    chk("midrst_level", bus.level, 2'b00);
    @(negedge clk);
    rstn = 1'b1;
    watch(2'b00, 2'b00, 99, 12, 0, r_at, f_at, r_cnt, led_cnt);
    chki("midrst_rise_cnt", r_cnt, 0);
    chk("midrst_level_after", bus.level, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rs232_ctrl_monitor.md
Name: rs232_ctrl_monitor

Overview:
Parametrised monitor for RS232 modem-control lines (DTR, RTS, and optionally CTS, DSR, DCD, RI) arriving asynchronously from the USB-serial bridge. Each channel is synchronised, debounced and edge-detected, then drives an LED in a selectable display mode. It provides clean level and edge-pulse outputs for downstream logic, such as the UART reset-on-DTR and flow control.

Parameters:
N_CH, 2, number of control-line channels (1..8)
SYNC_STAGES, 2, synchroniser flops per channel (>=2)
DEB_CYCLES, 1200, consecutive cycles a new value must persist before acceptance (>=1; 100 us at 12 MHz)
STRETCH_CYCLES, 1200000, LED on-time after an edge in stretch mode (>=1; 100 ms at 12 MHz)

Ports:
clk  in  1  system clock; the only clock in the block
rstn  in  1  asynchronous active-low reset
ctrl_in  in  N_CH  raw asynchronous control lines; bit 0 = DTR, bit 1 = RTS
mode  in  2  LED mode: 00 level, 01 inverted level, 10 toggle on rise, 11 edge stretch
clr  in  1  synchronous clear of the toggle and stretch state
level  out  N_CH  debounced line levels
rise  out  N_CH  one-cycle pulse on an accepted 0->1 change
fall  out  N_CH  one-cycle pulse on an accepted 1->0 change
led  out  N_CH  LED drive per the selected mode

Behaviour:
- Clocking and reset: one clock (clk); reset rstn is asynchronous and active-low.
- Reset values: all synchroniser flops, level, rise, fall, toggle flops, debounce counters and stretch counters are 0.
  - led is 0 in modes 00, 10 and 11; it is 1 in mode 01, because it is a combinational mux of state.
  - Mid-operation reset aborts any debounce or stretch in progress immediately.
- Synchroniser: SYNC_STAGES-flop chain per channel.
  - s = the last stage.
  - s follows a change on ctrl_in after SYNC_STAGES clk edges.
- Debounce (per channel):
  - Counter width is clog2(DEB_CYCLES+1).
  - When s == level, the counter is forced to 0.
  - When s != level, the counter increments each cycle.
  - At the edge where the counter equals DEB_CYCLES-1 and s != level, the block does all of the following: level <= s, counter <= 0, and asserts rise or fall (registered, same edge) for exactly one cycle.
  - A glitch shorter than DEB_CYCLES cycles at s produces no change.
  - A bounce restarts the count from 0.
- Total latency from a stable change on ctrl_in to level/rise/fall: SYNC_STAGES + DEB_CYCLES edges.
- rise and fall are never both set on one channel in the same cycle. Channels are fully independent; simultaneous edges on different channels are all reported.
- Toggle flop (per channel):
  - Inverts on the same edge that rise is asserted.
  - Runs in all modes.
- Stretch counter (per channel):
  - Loaded with STRETCH_CYCLES on the same edge that rise or fall is asserted; otherwise it decrements while nonzero.
  - stretch_on = (counter != 0), so it is high for exactly STRETCH_CYCLES cycles starting in the rise/fall cycle.
  - It is retriggerable: a new edge reloads the full value.
  - It runs in all modes.
- LED mux (combinational): led = level, ~level, toggle, or stretch_on per mode.
  - A mode change takes effect in the same cycle.
  - Internal state is unaffected by a mode change.
- clr:
  - At the next edge it zeroes the toggle flops and stretch counters of all channels.
  - If clr coincides with an accepted edge, clr wins for toggle/stretch; level/rise/fall still update.
  - clr does not touch the synchronisers, debounce counters or level.
- Widths: all counters saturate-free by construction (load/compare bounds). Upper bits of ctrl_in are ignored only when N_CH < width; no truncation otherwise.

Test Plan:
(Bench parameters: N_CH=2, SYNC_STAGES=2, DEB_CYCLES=4, STRETCH_CYCLES=10.)
- Reset behaviour: hold rstn=0 with ctrl_in=11 -> level=00, rise=fall=00, led=00 (mode 00); release with ctrl_in held 11 -> level=11 and rise=11 pulse exactly 6 edges after the first post-reset edge.
- Glitch rejection: ch0 0->1 for 3 cycles then back to 0 -> level[0] stays 0 and no rise; a 4-cycle pulse instead -> level[0]=1 and rise[0] for one cycle, then fall[0] 4 cycles after s returns to 0.
- Toggle mode (mode=10): three clean rising edges on ch1 -> led[1] goes 1,0,1. A falling edge -> no change. Assert clr -> led[1]=0 next cycle while level[1] holds.
- Stretch mode (mode=11): one edge on ch0 -> led[0] high for exactly 10 cycles. A second edge 6 cycles in -> led[0] stays high 10 more cycles from the retrigger.
- Mode switching and reset: in mode 01, level=10 -> led=01. Assert rstn mid-debounce (count 2) -> after release, no spurious rise and level=00.
